// File: rtl/raytracing_line_collector.sv
// Row sequencer for the raytracing workers: sets up each row, launches
// the workers, waits for them to finish and drains their colour buffers
// into the framebuffer in x order.
// Ports: clk, rst (sync, active high), start, worker_busy[N],
//   worker_buffer[N*J*12] in; activate, pixel_y, pixel_y_sqrd,
//   fb_wr_valid/fb_wr_ready, fb_wr_addr, fb_wr_data, busy, frame_done.
// Optional: RT_COLLECTOR_CHECKSUM_EN adds row_checksum and
//   row_checksum_valid (per-row 16-bit sum of written pixels).
module raytracing_line_collector #(
   parameter int N_WORKERS        = 10,
   parameter int JOBS_SUBDIVISION = 64,
   parameter int ROWS             = 480
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_WORKERS-1:0] worker_busy,
   input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer,
   output logic                activate,
   output logic signed [9:0]   pixel_y,
   output logic [16:0]         pixel_y_sqrd,
   output logic                fb_wr_valid,
   input  logic                fb_wr_ready,
   output logic [18:0]         fb_wr_addr,
   output logic [11:0]         fb_wr_data,
   output logic                busy,
   output logic                frame_done
`ifdef RT_COLLECTOR_CHECKSUM_EN
   ,
   output logic [15:0]         row_checksum,
   output logic                row_checksum_valid
`endif
);

   localparam int WW = (N_WORKERS > 1) ?
      $clog2(N_WORKERS) : 1;
   localparam int JW = (JOBS_SUBDIVISION > 1) ?
      $clog2(JOBS_SUBDIVISION) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_LAUNCH   = 3'd2;
   localparam logic [2:0] S_RENDER   = 3'd3;
   localparam logic [2:0] S_DRAIN    = 3'd4;
   localparam logic [2:0] S_NEXT_ROW = 3'd5;

   logic [2:0]           state;
   logic [9:0]           row;
   logic [N_WORKERS-1:0] seen;
   logic [WW-1:0]        wrk;
   logic [JW-1:0]        job;
   logic [9:0]           y_c;
   logic [9:0]           y_mag;
   logic                 all_seen;
   logic                 last_row;
   logic                 last_wrk;
   logic                 last_pix;
   logic                 xfer;

   // 240-row in two's complement; the square uses the magnitude
   assign y_c      = 10'd240 - row;
   assign y_mag    = y_c[9] ? (~y_c + 10'd1) : y_c;
   assign all_seen = &seen;
   assign last_row = (row == 10'(ROWS - 1));
   assign last_wrk = (wrk == WW'(N_WORKERS - 1));
   assign last_pix = last_wrk &&
      (job == JW'(JOBS_SUBDIVISION - 1));

   // valid is gated by rst so a reset edge never completes a write
   assign fb_wr_valid = (state == S_DRAIN) && !rst;
   assign xfer        = (state == S_DRAIN) && fb_wr_ready;
   assign activate    = (state == S_LAUNCH) ||
                        (state == S_RENDER);
   assign busy        = (state != S_IDLE);
   assign frame_done  = (state == S_NEXT_ROW) && last_row;

   // pixel x lives in worker x mod N, job x div N
   assign fb_wr_data = worker_buffer[
      (int'(wrk) * JOBS_SUBDIVISION + int'(job)) * 12 +: 12];

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         row          <= '0;
         seen         <= '0;
         wrk          <= '0;
         job          <= '0;
         fb_wr_addr   <= '0;
         pixel_y      <= '0;
         pixel_y_sqrd <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_SETUP;
                  row        <= '0;
                  fb_wr_addr <= '0;
               end
            end
            S_SETUP: begin
               pixel_y      <= y_c;
               pixel_y_sqrd <= 17'(y_mag * y_mag);
               seen         <= '0;
               wrk          <= '0;
               job          <= '0;
               state        <= S_LAUNCH;
            end
            S_LAUNCH: begin
               seen <= seen | worker_busy;
               if (all_seen)
                  state <= S_RENDER;
            end
            S_RENDER: begin
               seen <= seen | worker_busy;
               if (all_seen && (worker_busy == '0))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (xfer) begin
                  fb_wr_addr <= fb_wr_addr + 19'd1;
                  if (last_wrk) begin
                     wrk <= '0;
                     job <= job + JW'(1);
                  end else begin
                     wrk <= wrk + WW'(1);
                  end
                  if (last_pix)
                     state <= S_NEXT_ROW;
               end
            end
            S_NEXT_ROW: begin
               if (last_row) begin
                  state <= S_IDLE;
               end else begin
                  row   <= row + 10'd1;
                  state <= S_SETUP;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RT_COLLECTOR_CHECKSUM_EN
   logic [15:0] csum;

   assign row_checksum       = csum;
   assign row_checksum_valid = (state == S_NEXT_ROW);

   always_ff @(posedge clk) begin
      if (rst)
         csum <= '0;
      else if (state == S_SETUP)
         csum <= '0;
      else if (xfer)
         csum <= csum + 16'(fb_wr_data);
   end
`endif

endmodule
